ifetch_queue: RTL

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - direct-mapped icache with line refill FSM feeding a show-ahead instruction queue
module ifetch_queue #(
   parameter int ICACHE_LINES = 64,
   parameter int LINE_WORDS   = 4,
   parameter int IQ_DEPTH     = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   output logic [31:0] mem_addr_out,
   output logic        mem_en_out,
   output logic        mem_drop_out,
   input  logic [31:0] mem_data_in,
   input  logic        mem_ok_in,
   output logic [31:0] pred_pc_out,
   output logic [31:0] pred_inst_out,
   input  logic        pred_taken_in,
   input  logic [31:0] pred_imm_in,
   output logic        iq_valid_out,
   input  logic        iq_ready_in,
   output logic [31:0] iq_inst_out,
   output logic [31:0] iq_pc_out,
   output logic [31:0] iq_rollback_pc_out,
   output logic        iq_pred_taken_out,
   input  logic        rob_rollback_in,
   input  logic [31:0] rob_target_pc_in
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int OW    = (OFF_W > 0) ? OFF_W : 1;
   localparam int IDX_W = $clog2(ICACHE_LINES);
   localparam int TAG_W = 30 - OFF_W - IDX_W;
   localparam int QW    = $clog2(IQ_DEPTH);
   localparam logic [OW-1:0] LAST_WORD = OW'(LINE_WORDS - 1);
   localparam logic [31:0]   OFF_MASK  = 32'(LINE_WORDS * 4 - 1);
   localparam logic [QW:0]   CNT_FULL  = (QW + 1)'(IQ_DEPTH);

   typedef enum logic {IDLE = 1'b0, REFILL = 1'b1} state_t;

   state_t state, state_nxt;

   // Cache storage; only the valid bits need a reset value
   logic [31:0]             line_data [ICACHE_LINES][LINE_WORDS];
   logic [TAG_W-1:0]        line_tag  [ICACHE_LINES];
   logic [ICACHE_LINES-1:0] line_valid;

   // Instruction queue storage
   logic [31:0] q_inst [IQ_DEPTH];
   logic [31:0] q_pc   [IQ_DEPTH];
   logic [31:0] q_rb   [IQ_DEPTH];
   logic        q_tk   [IQ_DEPTH];
   logic [QW-1:0] rd_ptr, wr_ptr;
   logic [QW:0]   count;

   logic [31:0]      pc;
   logic [OW-1:0]    pc_off;
   logic [IDX_W-1:0] pc_idx;
   logic [TAG_W-1:0] pc_tag;
   logic             hit;
   logic [31:0]      hit_word;

   // Refill bookkeeping: the line being filled and the next word slot
   logic [OW-1:0]    cnt, cnt_nxt;
   logic [IDX_W-1:0] ref_idx, ref_idx_nxt;
   logic [TAG_W-1:0] ref_tag, ref_tag_nxt;
   logic [31:0]      addr_nxt;
   logic             en_nxt, drop_nxt;
   logic             line_clr, line_wr, line_fill;

   logic rollback, push, pop;

   if (OFF_W > 0) begin : g_off
      assign pc_off = pc[2 +: OW];
   end else begin : g_no_off
      assign pc_off = '0;
   end
   assign pc_idx = pc[2 + OFF_W +: IDX_W];
   assign pc_tag = pc[31 -: TAG_W];

   assign hit      = line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag);
   assign hit_word = line_data[pc_idx][pc_off];

   // Freeze (rdy_in low) masks rollback; rollback masks push and pop
   assign rollback = rdy_in && rob_rollback_in;
   assign push     = rdy_in && !rob_rollback_in && hit && (count != CNT_FULL);
   assign pop      = rdy_in && !rob_rollback_in && (count != '0) && iq_ready_in;

   assign pred_pc_out        = pc;
   assign pred_inst_out      = hit ? hit_word : 32'h0;
   assign iq_valid_out       = (count != '0);
   assign iq_inst_out        = iq_valid_out ? q_inst[rd_ptr] : 32'h0;
   assign iq_pc_out          = iq_valid_out ? q_pc[rd_ptr]   : 32'h0;
   assign iq_rollback_pc_out = iq_valid_out ? q_rb[rd_ptr]   : 32'h0;
   assign iq_pred_taken_out  = iq_valid_out ? q_tk[rd_ptr]   : 1'b0;

   // Fetch pc: restart on rollback, otherwise advance only when an entry is pushed
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pc <= 32'h0;
      end else if (rollback) begin
         pc <= rob_target_pc_in;
      end else if (push) begin
         pc <= pc + (pred_taken_in ? pred_imm_in : 32'd4);
      end
   end

   // Queue pointers and occupancy; rollback empties the queue
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (rollback) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (rdy_in) begin
         if (push) wr_ptr <= wr_ptr + QW'(1);
         if (pop)  rd_ptr <= rd_ptr + QW'(1);
         case ({push, pop})
            2'b10:   count <= count + (QW + 1)'(1);
            2'b01:   count <= count - (QW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Queue entry write
   always_ff @(posedge clk_in) begin
      if (push) begin
         q_inst[wr_ptr] <= hit_word;
         q_pc[wr_ptr]   <= pc;
         q_rb[wr_ptr]   <= pc + 32'd4;
         q_tk[wr_ptr]   <= pred_taken_in;
      end
   end

   // Refill FSM next state and memory request generation
   always_comb begin
      state_nxt   = state;
      addr_nxt    = mem_addr_out;
      en_nxt      = 1'b0;
      drop_nxt    = 1'b0;
      cnt_nxt     = cnt;
      ref_idx_nxt = ref_idx;
      ref_tag_nxt = ref_tag;
      line_clr    = 1'b0;
      line_wr     = 1'b0;
      line_fill   = 1'b0;
      if (rob_rollback_in) begin
         drop_nxt  = 1'b1;
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (!hit) begin
                  ref_idx_nxt = pc_idx;
                  ref_tag_nxt = pc_tag;
                  cnt_nxt     = '0;
                  line_clr    = 1'b1;
                  addr_nxt    = pc & ~OFF_MASK;
                  en_nxt      = 1'b1;
                  state_nxt   = REFILL;
               end
            end
            REFILL: begin
               if (mem_ok_in) begin
                  line_wr = 1'b1;
                  if (cnt == LAST_WORD) begin
                     line_fill = 1'b1;
                     state_nxt = IDLE;
                  end else begin
                     cnt_nxt  = cnt + OW'(1);
                     addr_nxt = mem_addr_out + 32'd4;
                     en_nxt   = 1'b1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Refill FSM state register and registered memory-side outputs
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state        <= IDLE;
         mem_addr_out <= 32'h0;
         mem_en_out   <= 1'b0;
         mem_drop_out <= 1'b0;
         cnt          <= '0;
         ref_idx      <= '0;
         ref_tag      <= '0;
      end else if (rdy_in) begin
         state        <= state_nxt;
         mem_addr_out <= addr_nxt;
         mem_en_out   <= en_nxt;
         mem_drop_out <= drop_nxt;
         cnt          <= cnt_nxt;
         ref_idx      <= ref_idx_nxt;
         ref_tag      <= ref_tag_nxt;
      end
   end

   // Line valid bits: invalidate when a refill starts, validate on the last word
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         line_valid <= '0;
      end else if (rdy_in) begin
         if (line_clr)  line_valid[pc_idx]  <= 1'b0;
         if (line_fill) line_valid[ref_idx] <= 1'b1;
      end
   end

   // Line data and tag write during refill
   always_ff @(posedge clk_in) begin
      if (rdy_in && !rst_in) begin
         if (line_wr)   line_data[ref_idx][cnt] <= mem_data_in;
         if (line_fill) line_tag[ref_idx]       <= ref_tag;
      end
   end

endmodule
